// File: rtl/input_port.sv
// input_port: samples slide switches and push-buttons for the CPU's
// memory-mapped input ports.
//   clock     - system clock, rising edge
//   resetn    - asynchronous active-low reset
//   sw[9:0]   - raw slide switches (asynchronous)
//   key[2:0]  - raw push-buttons, active-low, bouncing (asynchronous)
//   in_port0  - min(sw[4:0], SW_CLAMP), zero-extended
//   in_port1  - min(sw[9:5], SW_CLAMP), zero-extended
//   in_port2  - decimal up/down counter 0..CNT_MAX driven by the keys
//   key_event - one-cycle pulse per debounced press of each key
module input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_MAX         = 99,
  parameter int unsigned SW_CLAMP        = 19
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic [2:0]  key,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [31:0] in_port2,
  output logic [2:0]  key_event
);

  localparam int unsigned NKEY  = 3;
  localparam int unsigned SW_W  = 5;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned VAL_W = 7;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW_W-1:0]  CLAMP    = SW_W'(SW_CLAMP);
  localparam logic [VAL_W-1:0] WRAP     = VAL_W'(CNT_MAX);

  // Two-flop synchronisers
  logic [9:0]      sw_meta_q, sw_sync_q;
  logic [NKEY-1:0] key_meta_q, key_sync_q;

  // Switch path
  logic [SW_W-1:0] port0_q, port0_d;
  logic [SW_W-1:0] port1_q, port1_d;

  // Debounce state
  logic [NKEY-1:0]  stable_q, stable_d;
  logic [NKEY-1:0]  stable_prev_q;
  logic [CNT_W-1:0] deb_cnt_q [NKEY];
  logic [CNT_W-1:0] deb_cnt_d [NKEY];

  // Press qualification: a key is armed once a genuine released level has
  // been seen after reset, so a key held through reset yields no event.
  logic [1:0]      valid_q;
  logic [NKEY-1:0] armed_q, armed_d;

  logic [NKEY-1:0]  event_q, event_d;
  logic [VAL_W-1:0] cnt_q, cnt_d;

  // Switch clamp
  always_comb begin
    port0_d = (sw_sync_q[4:0] > CLAMP) ? CLAMP : sw_sync_q[4:0];
    port1_d = (sw_sync_q[9:5] > CLAMP) ? CLAMP : sw_sync_q[9:5];
  end

  // Per-key debounce: accept a new level after DEBOUNCE_CYCLES consecutive
  // disagreeing synchronised samples; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NKEY; i++) begin
      deb_cnt_d[i] = '0;
      if (key_sync_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = key_sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press events: accepted level fell 1->0 on the previous edge
  always_comb begin
    armed_d = armed_q | (key_sync_q & {NKEY{valid_q[1]}});
    event_d = stable_prev_q & ~stable_q & armed_q;
  end

  // Counter: clear wins; simultaneous up and down cancel
  always_comb begin
    cnt_d = cnt_q;
    if (event_q[2]) begin
      cnt_d = '0;
    end else if (event_q[0] && !event_q[1]) begin
      cnt_d = (cnt_q == WRAP) ? '0 : cnt_q + VAL_W'(1);
    end else if (event_q[1] && !event_q[0]) begin
      cnt_d = (cnt_q == '0) ? WRAP : cnt_q - VAL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      key_meta_q    <= '1;
      key_sync_q    <= '1;
      port0_q       <= '0;
      port1_q       <= '0;
      stable_q      <= '1;
      stable_prev_q <= '1;
      for (int i = 0; i < NKEY; i++) deb_cnt_q[i] <= '0;
      valid_q       <= '0;
      armed_q       <= '0;
      event_q       <= '0;
      cnt_q         <= '0;
    end else begin
      sw_meta_q     <= sw;
      sw_sync_q     <= sw_meta_q;
      key_meta_q    <= key;
      key_sync_q    <= key_meta_q;
      port0_q       <= port0_d;
      port1_q       <= port1_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < NKEY; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      valid_q       <= {valid_q[0], 1'b1};
      armed_q       <= armed_d;
      event_q       <= event_d;
      cnt_q         <= cnt_d;
    end
  end

  assign in_port0  = {27'd0, port0_q};
  assign in_port1  = {27'd0, port1_q};
  assign in_port2  = {25'd0, cnt_q};
  assign key_event = event_q;

endmodule
